// File: rtl/uart_bridge_if.sv
// Core data-bus view of the UART bridge register window.
interface uart_bridge_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output addr, output we, output re, output wdata, input rdata);
  modport slave  (input sel, input addr, input we, input re, input wdata, output rdata);
endinterface

// File: rtl/uart_bridge.sv
// Memory-mapped UART front end: RX/TX byte FIFOs, STATUS/CTRL registers,
// a two-state TX offer FSM, and an occupancy-driven interrupt.
module uart_bridge #(
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_bridge_if.slave   bus,
  output logic [7:0]     tx_data,
  output logic           tx_data_valid,
  input  logic           tx_data_ack,
  input  logic [7:0]     rx_data,
  input  logic           rx_data_fresh,
  output logic           irq
);

  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_ONE = 1;
  localparam logic [TX_AW:0] TX_ONE = 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} tx_state_e;

  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [7:0]     rx_mem_d [RX_DEPTH];
  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [7:0]     tx_mem_d [TX_DEPTH];
  logic [RX_AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic           rx_overrun_q, rx_overrun_d;
  logic           tx_drop_q, tx_drop_d;
  logic [1:0]     ctrl_q, ctrl_d;
  tx_state_e      state_q, state_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic           irq_q, irq_d;

  logic           rx_empty, rx_full, tx_empty, tx_full;
  logic           data_acc, stat_wr, ctrl_wr;
  logic           rx_pop, rx_push, tx_pop, tx_wr_req, tx_push;
  logic [RX_AW:0] rx_count;
  logic [31:0]    rx_count32;
  logic [3:0]     rx_count_sat;
  logic [31:0]    status;
  logic           unused_wdata;

  assign unused_wdata = ^bus.wdata[31:8];

  always_comb begin
    rx_empty     = (rx_wr_q == rx_rd_q);
    rx_full      = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                   (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
    tx_empty     = (tx_wr_q == tx_rd_q);
    tx_full      = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                   (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
    rx_count     = rx_wr_q - rx_rd_q;
    rx_count32   = 32'(rx_count);
    rx_count_sat = (rx_count32 > 32'd15) ? 4'hF : rx_count32[3:0];
    status       = {20'h0, rx_count_sat, 2'b00, tx_drop_q, rx_overrun_q,
                    tx_empty, tx_full, rx_full, ~rx_empty};

    data_acc  = bus.sel && (bus.addr == 2'd0);
    stat_wr   = bus.sel && bus.we && (bus.addr == 2'd1);
    ctrl_wr   = bus.sel && bus.we && (bus.addr == 2'd2);
    // A pop frees a slot this edge, so a push into a full FIFO still lands.
    rx_pop    = data_acc && bus.re && !rx_empty;
    rx_push   = rx_data_fresh && (!rx_full || rx_pop);
    tx_pop    = (state_q == SEND) && tx_data_ack;
    tx_wr_req = data_acc && bus.we;
    tx_push   = tx_wr_req && (!tx_full || tx_pop);
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr)
        2'd0:    bus.rdata = rx_empty ? '0 : {24'h0, rx_mem_q[rx_rd_q[RX_AW-1:0]]};
        2'd1:    bus.rdata = status;
        2'd2:    bus.rdata = {30'h0, ctrl_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    rx_mem_d = rx_mem_q;
    tx_mem_d = tx_mem_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    ctrl_d   = ctrl_q;

    if (rx_push) begin
      rx_mem_d[rx_wr_q[RX_AW-1:0]] = rx_data;
      rx_wr_d = rx_wr_q + RX_ONE;
    end
    if (rx_pop) rx_rd_d = rx_rd_q + RX_ONE;

    if (tx_push) begin
      tx_mem_d[tx_wr_q[TX_AW-1:0]] = bus.wdata[7:0];
      tx_wr_d = tx_wr_q + TX_ONE;
    end
    if (tx_pop) tx_rd_d = tx_rd_q + TX_ONE;

    // Set events are OR-ed in after the clear so they win a same-cycle W1C.
    rx_overrun_d = (rx_overrun_q && !(stat_wr && bus.wdata[4])) ||
                   (rx_data_fresh && rx_full && !rx_pop);
    tx_drop_d    = (tx_drop_q && !(stat_wr && bus.wdata[5])) ||
                   (tx_wr_req && tx_full && !tx_pop);

    if (ctrl_wr) ctrl_d = bus.wdata[1:0];

    irq_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty && (state_q == IDLE));
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_data_d  = tx_mem_q[tx_rd_q[TX_AW-1:0]];
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_data_ack) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_mem_q     <= '{default: '0};
      tx_mem_q     <= '{default: '0};
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      ctrl_q       <= '0;
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      rx_mem_q     <= rx_mem_d;
      tx_mem_q     <= tx_mem_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
      ctrl_q       <= ctrl_d;
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      irq_q        <= irq_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign irq           = irq_q;

endmodule
